// File: rtl/pixel_cursor_ctrl.sv
// Cursor controller for a WIDTH x HEIGHT pixel board: row-scans for the first
// lit pixel, then tracks a cursor moved by rising edges of l/r/u/d.
module pixel_cursor_ctrl #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP   = 1,
    parameter int HOME_X = 3,
    parameter int HOME_Y = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           l,
    input  logic                           r,
    input  logic                           u,
    input  logic                           d,
    input  logic                           rescan,
    input  logic [HEIGHT-1:0][WIDTH-1:0]   pixel_board,
    output logic [$clog2(WIDTH)-1:0]       cursor_x,
    output logic [$clog2(HEIGHT)-1:0]      cursor_y,
    output logic [HEIGHT-1:0][WIDTH-1:0]   cursor_mask,
    output logic                           found,
    output logic                           busy,
    output logic                           moved
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic {SCAN, TRACK} state_t;

    state_t          r_state, w_stateNext;
    logic [YW-1:0]   r_scanRow, w_scanRowNext;
    logic [XW-1:0]   r_x, w_xNext, w_xMoved, w_lowX;
    logic [YW-1:0]   r_y, w_yNext, w_yMoved;
    logic            r_found, w_foundNext;
    logic            r_moved, w_movedNext;
    logic [3:0]      r_prev;
    logic [3:0]      w_edges;
    logic [WIDTH-1:0] w_rowBits;
    logic            w_rowHit;
    logic [XW:0]     w_xInc, w_xDec;
    logic [YW:0]     w_yInc, w_yDec;

    // Edge bits ordered {l, r, u, d}
    assign w_edges   = {l, r, u, d} & ~r_prev;
    assign w_rowBits = pixel_board[r_scanRow];
    assign w_rowHit  = |w_rowBits;

    always_comb begin
        w_lowX = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_rowBits[i]) w_lowX = XW'(i);
        end
    end

    // One extra bit exposes underflow/overflow before wrapping or clamping
    assign w_xInc = {1'b0, r_x} + (XW+1)'(1);
    assign w_xDec = {1'b0, r_x} - (XW+1)'(1);
    assign w_yInc = {1'b0, r_y} + (YW+1)'(1);
    assign w_yDec = {1'b0, r_y} - (YW+1)'(1);

    always_comb begin
        w_xMoved = r_x;
        w_yMoved = r_y;
        if (w_edges[3] && !w_edges[2]) begin
            if (w_xDec[XW]) w_xMoved = (WRAP != 0) ? XW'(WIDTH - 1) : r_x;
            else            w_xMoved = w_xDec[XW-1:0];
        end else if (w_edges[2] && !w_edges[3]) begin
            if (w_xInc == (XW+1)'(WIDTH)) w_xMoved = (WRAP != 0) ? '0 : r_x;
            else                          w_xMoved = w_xInc[XW-1:0];
        end
        if (w_edges[1] && !w_edges[0]) begin
            if (w_yDec[YW]) w_yMoved = (WRAP != 0) ? YW'(HEIGHT - 1) : r_y;
            else            w_yMoved = w_yDec[YW-1:0];
        end else if (w_edges[0] && !w_edges[1]) begin
            if (w_yInc == (YW+1)'(HEIGHT)) w_yMoved = (WRAP != 0) ? '0 : r_y;
            else                           w_yMoved = w_yInc[YW-1:0];
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_scanRowNext = r_scanRow;
        w_xNext       = r_x;
        w_yNext       = r_y;
        w_foundNext   = r_found;
        w_movedNext   = 1'b0;
        case (r_state)
            SCAN: begin
                if (rescan) begin
                    w_scanRowNext = '0;
                end else if (w_rowHit) begin
                    w_xNext     = w_lowX;
                    w_yNext     = r_scanRow;
                    w_foundNext = 1'b1;
                    w_stateNext = TRACK;
                end else if (r_scanRow == YW'(HEIGHT - 1)) begin
                    w_xNext     = XW'(HOME_X);
                    w_yNext     = YW'(HOME_Y);
                    w_foundNext = 1'b0;
                    w_stateNext = TRACK;
                end else begin
                    w_scanRowNext = r_scanRow + YW'(1);
                end
            end
            TRACK: begin
                if (rescan) begin
                    w_stateNext   = SCAN;
                    w_scanRowNext = '0;
                end else begin
                    w_xNext     = w_xMoved;
                    w_yNext     = w_yMoved;
                    w_movedNext = (w_xMoved != r_x) || (w_yMoved != r_y);
                end
            end
            default: w_stateNext = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= SCAN;
            r_scanRow <= '0;
            r_x       <= XW'(HOME_X);
            r_y       <= YW'(HOME_Y);
            r_found   <= 1'b0;
            r_moved   <= 1'b0;
            r_prev    <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_scanRow <= w_scanRowNext;
            r_x       <= w_xNext;
            r_y       <= w_yNext;
            r_found   <= w_foundNext;
            r_moved   <= w_movedNext;
            r_prev    <= {l, r, u, d};
        end
    end

    always_comb begin
        cursor_mask           = '0;
        cursor_mask[r_y][r_x] = 1'b1;
    end

    assign cursor_x = r_x;
    assign cursor_y = r_y;
    assign found    = r_found;
    assign busy     = (r_state == SCAN);
    assign moved    = r_moved;

endmodule
